// File: rtl/si_sat_downscaler_pkg.sv
// Shared helpers for the signed-integer scaler family.
// Signed range limits for an n-bit two's-complement value.
package si_sat_downscaler_pkg;

  function automatic int si_max(input int n);
    return (1 << (n - 1)) - 1;
  endfunction

  function automatic int si_min(input int n);
    return -(1 << (n - 1));
  endfunction

endpackage

// File: rtl/si_round_shift.sv
// Arithmetic right shift with round-half-up.
// One guard bit above N_IN keeps +max input from wrapping.
module si_round_shift #(
  parameter int N_IN  = 16,
  parameter int SHIFT = 4
) (
  input  logic signed [N_IN-1:0] x_i,
  output logic signed [N_IN:0]   r_o
);

  logic signed [N_IN:0] ext;
  assign ext = {x_i[N_IN-1], x_i};

  if (SHIFT == 0) begin : g_pass
    assign r_o = ext;
  end else begin : g_rnd
    localparam logic signed [N_IN:0] HALF =
      {{N_IN{1'b0}}, 1'b1} << (SHIFT - 1);
    logic signed [N_IN:0] sum;
    assign sum = ext + HALF;
    assign r_o = sum >>> SHIFT;
  end

endmodule

// File: rtl/si_sat_downscaler.sv
// Two-stage narrowing pipeline: round-shift, then clamp to N_OUT.
// Counts saturated output transfers (sticky at max).
module si_sat_downscaler #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 8,
  parameter int SHIFT = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N_OUT-1:0] out_data,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_count,
  output logic [CNT_W-1:0] sat_count
);
  import si_sat_downscaler_pkg::*;

  localparam logic signed [N_IN:0] HI =
    (N_IN+1)'(si_max(N_OUT));
  localparam logic signed [N_IN:0] LO =
    (N_IN+1)'(si_min(N_OUT));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                    s1_valid_q, s1_valid_d;
  logic signed [N_IN:0]    s1_r_q, s1_r_d;
  logic                    ov_q, ov_d;
  logic [N_OUT-1:0]        od_q, od_d;
  logic                    os_q, os_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic signed [N_IN:0]    rs;
  logic [N_OUT-1:0]        clamp;
  logic                    clamp_sat;
  logic                    s1_adv, s2_adv;

  si_round_shift #(
    .N_IN  (N_IN),
    .SHIFT (SHIFT)
  ) u_rs (
    .x_i (in_data),
    .r_o (rs)
  );

  assign s2_adv   = ~ov_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    clamp     = s1_r_q[N_OUT-1:0];
    clamp_sat = 1'b0;
    if (s1_r_q > HI) begin
      clamp     = HI[N_OUT-1:0];
      clamp_sat = 1'b1;
    end else if (s1_r_q < LO) begin
      clamp     = LO[N_OUT-1:0];
      clamp_sat = 1'b1;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_r_d     = s1_r_q;
    ov_d       = ov_q;
    od_d       = od_q;
    os_d       = os_q;
    cnt_d      = cnt_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_r_d = rs;
    end
    if (s2_adv) begin
      ov_d = s1_valid_q;
      if (s1_valid_q) begin
        od_d = clamp;
        os_d = clamp_sat;
      end
    end
    // Clear beats a same-cycle increment.
    if (clr_count) cnt_d = '0;
    else if (ov_q && out_ready && os_q && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_r_q     <= '0;
      ov_q       <= 1'b0;
      od_q       <= '0;
      os_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_r_q     <= s1_r_d;
      ov_q       <= ov_d;
      od_q       <= od_d;
      os_q       <= os_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_sat   = os_q;
  assign sat_count = cnt_q;

endmodule

// File: tb/tb_si_sat_downscaler.sv
// Bench for si_sat_downscaler: reference model plus directed vectors.
// Model uses real-valued rounding and explicit clamping.
module tb_si_sat_downscaler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        clr_count = 1'b0;
  logic [3:0]  sat_count;

  int checks = 0;
  int errors = 0;

  logic [8:0]  exp_q[$];
  int          mcnt = 0;
  logic        held_v = 1'b0;
  logic [7:0]  held_d;
  logic        held_s;

  si_sat_downscaler #(
    .N_IN  (16),
    .N_OUT (8),
    .SHIFT (4),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clr_count (clr_count),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // {sat, data}: round x/16 half toward +inf, clamp to int8.
  function automatic logic [8:0] model(input logic [15:0] x);
    real v;
    int  r;
    v = $itor($signed(x)) / 16.0;
    r = int'($floor(v + 0.5));
    if (r > 127)  return {1'b1, 8'h7f};
    if (r < -128) return {1'b1, 8'h80};
    return {1'b0, r[7:0]};
  endfunction

  always @(negedge clk) begin
    logic [8:0] e;
    logic       xfer_sat;
    if (rst) begin
      exp_q.delete();
      mcnt   = 0;
      held_v = 1'b0;
    end else begin
      xfer_sat = 1'b0;
      chk("sat_count", int'(sat_count), mcnt);
      if (held_v) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(held_d));
        chk("hold_sat", int'(out_sat), int'(held_s));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", int'(out_data), int'(e[7:0]));
          chk("out_sat", int'(out_sat), int'(e[8]));
          xfer_sat = e[8];
        end
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_s = out_sat;
      if (clr_count) mcnt = 0;
      else if (xfer_sat && mcnt < 15) mcnt++;
      if (in_valid && in_ready) exp_q.push_back(model(in_data));
    end
  end

  task automatic send(input logic [15:0] x);
    in_data  = x;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("send_timeout", 1, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0) return;
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  logic [15:0] vec[10] = '{
    16'h0100, 16'h07f0, 16'h0000, 16'h0018, 16'hffe8,
    16'hfff8, 16'h07f8, 16'h7fff, 16'h8000, 16'hf800
  };
  logic [8:0] lit[10] = '{
    9'h010, 9'h07f, 9'h000, 9'h002, 9'h0ff,
    9'h000, 9'h17f, 9'h17f, 9'h180, 9'h080
  };

  initial begin
    for (int i = 0; i < 10; i++)
      chk($sformatf("model_%0h", vec[i]), int'(model(vec[i])), int'(lit[i]));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    chk("rst_sat_count", int'(sat_count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) send(vec[i]);
    drain();
    chk("cnt_after_vecs", int'(sat_count), 3);

    // Backpressure: A enters, B follows, C blocked.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_data = 16'h0230; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 16'hfe10;
    @(posedge clk); #1;
    in_data = 16'h0055;
    @(negedge clk);
    chk("bp_in_ready", int'(in_ready), 0);
    chk("bp_inflight", exp_q.size(), 2);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_still_blocked", int'(in_ready), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && in_valid; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
      end
    end
    chk("bp_c_taken", int'(in_valid), 0);
    drain();

    // Counter saturates at 15 and holds.
    @(posedge clk); #1 clr_count = 1'b1;
    @(posedge clk); #1 clr_count = 1'b0;
    for (int i = 0; i < 20; i++) send(16'h7fff);
    drain();
    @(posedge clk); #1;
    chk("cnt_held", int'(sat_count), 15);

    // Clear coincident with a saturating transfer.
    out_ready = 1'b0;
    send(16'h8000);
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("clr_wait_valid", int'(out_valid), 1);
    clr_count = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    chk("cnt_clr_wins", int'(sat_count), 0);
    drain();

    // Reset with two samples in flight.
    send(16'h7fff);
    drain();
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(16'h0100);
    send(16'h0200);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_out_valid", int'(out_valid), 0);
    chk("rst2_sat_count", int'(sat_count), 0);
    chk("rst2_in_ready", int'(in_ready), 1);
    rst = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst2_no_stale", int'(out_valid), 0);
    chk("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
